// File: rtl/esc_pin_mux.sv
// -----------------------------------------------------------------------------
// esc_pin_mux
//
// Pad stage for a single ESC signal pin. Owns the pin driver and arbitrates
// between the DSHOT generator and the half-duplex UART passthrough bridge.
//
// Mode sequencing:
//   DSHOT -> DRAIN (current DSHOT frame finishes)
//         -> SETTLE (pin held idle-high for SETTLE_CYCLES)
//         -> PASS (bridge owns the pin)
//         -> RELEASE (waits for the bridge transmitter to let go, then a guard)
//         -> DSHOT
//
// The pin input is synchronized through two flops. The copy sent to the bridge
// receiver is forced high while this block drives the pin, and for
// GUARD_CYCLES afterwards, so the bridge never hears its own transmission.
//
// Optional feature, selected by the macro ESC_MUX_AUTO_REVERT_EN:
//   defined   - a PASS inactivity counter forces RELEASE after
//               IDLE_TIMEOUT_CYCLES idle cycles, pulses timeout_evt, and sets a
//               lock that blocks re-entry until mode_req returns to 0.
//   undefined - no counter; timeout_evt is 0; PASS exits only on mode_req=0.
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   mode_req         1 = passthrough requested, 0 = DSHOT
//   dshot_out        DSHOT generator serial data
//   dshot_busy       DSHOT frame in progress
//   dshot_inhibit    1 = DSHOT generator must not start a new frame
//   serial_tx_out    bridge transmit data
//   serial_tx_oe     bridge output enable
//   serial_rx_in     synchronized, echo-blanked pin data to the bridge
//   serial_activity  bridge activity status
//   passthrough_en   bridge enable
//   pad_in           raw asynchronous pin input
//   pad_out          pin output data
//   pad_oe           pin output enable
//   mode_state       state encoding (DSHOT=0 DRAIN=1 SETTLE=2 PASS=3 RELEASE=4)
//   timeout_evt      one-cycle pulse on an inactivity revert
//
// All outputs are registered. Output registers are loaded from the next state,
// so they change on the same edge as mode_state.
// -----------------------------------------------------------------------------
module esc_pin_mux #(
   parameter int unsigned CLK_FREQ_HZ         = 32'd72_000_000,
   parameter int unsigned SETTLE_CYCLES       = 32'd72_000,
   parameter int unsigned GUARD_CYCLES        = 32'd720,
   parameter int unsigned IDLE_TIMEOUT_CYCLES = 32'd360_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_req,
   input  logic       dshot_out,
   input  logic       dshot_busy,
   output logic       dshot_inhibit,
   input  logic       serial_tx_out,
   input  logic       serial_tx_oe,
   output logic       serial_rx_in,
   input  logic       serial_activity,
   output logic       passthrough_en,
   input  logic       pad_in,
   output logic       pad_out,
   output logic       pad_oe,
   output logic [2:0] mode_state,
   output logic       timeout_evt
);

   typedef enum logic [2:0] {
      ST_DSHOT   = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_PASS    = 3'd3,
      ST_RELEASE = 3'd4
   } mode_t;

   mode_t       state_r;
   mode_t       state_nxt_s;

   logic [31:0] settle_cnt_r;
   logic [31:0] guard_cnt_r;
   logic [31:0] echo_cnt_r;

   logic        pad_sync1_r;
   logic        pad_sync2_r;

   logic        pad_oe_r;
   logic        pad_out_r;
   logic        serial_rx_r;
   logic        passthrough_en_r;
   logic        dshot_inhibit_r;

   logic        pad_oe_nxt_s;
   logic        pad_out_nxt_s;
   logic        passthrough_en_nxt_s;
   logic        dshot_inhibit_nxt_s;

   logic        timeout_s;
   logic        lock_s;
   logic [31:0] unused_cfg_s;

`ifdef ESC_MUX_AUTO_REVERT_EN
   logic [31:0] idle_cnt_r;
   logic        pad_prev_r;
   logic        lock_r;
   logic        timeout_evt_r;
   logic        idle_clear_s;

   // Any sign of life on the link restarts the inactivity count.
   always_comb begin
      idle_clear_s = 1'b0;
      if (serial_activity || serial_tx_oe || (pad_prev_r && !pad_sync2_r)) begin
         idle_clear_s = 1'b1;
      end else begin
         idle_clear_s = 1'b0;
      end
   end

   // Timeout fires on the last idle count; a same-cycle activity clear wins.
   always_comb begin
      timeout_s = 1'b0;
      if ((state_r == ST_PASS) && !idle_clear_s &&
          (idle_cnt_r == (IDLE_TIMEOUT_CYCLES - 32'd1))) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Inactivity counter: zero outside PASS so it starts clean on entry, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_r <= 32'd0;
      end else if ((state_r != ST_PASS) || idle_clear_s) begin
         idle_cnt_r <= 32'd0;
      end else if (idle_cnt_r != 32'hFFFF_FFFF) begin
         idle_cnt_r <= idle_cnt_r + 32'd1;
      end
   end

   // Delayed copy of the synchronized pin for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         pad_prev_r <= 1'b1;
      end else begin
         pad_prev_r <= pad_sync2_r;
      end
   end

   // Lock blocks re-entry after a timeout until the requester drops mode_req;
   // dropping mode_req in the timeout cycle leaves it clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_r        <= 1'b0;
         timeout_evt_r <= 1'b0;
      end else begin
         timeout_evt_r <= timeout_s;
         if (!mode_req) begin
            lock_r <= 1'b0;
         end else if (timeout_s) begin
            lock_r <= 1'b1;
         end
      end
   end

   assign lock_s       = lock_r;
   assign timeout_evt  = timeout_evt_r;
   assign unused_cfg_s = CLK_FREQ_HZ;
`else
   assign timeout_s    = 1'b0;
   assign lock_s       = 1'b0;
   assign timeout_evt  = 1'b0;
   assign unused_cfg_s = CLK_FREQ_HZ ^ IDLE_TIMEOUT_CYCLES ^ {31'd0, serial_activity};
`endif

   // Next-state logic for the pin ownership sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_DSHOT: begin
            if (mode_req && !lock_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_DSHOT;
            end
         end
         ST_DRAIN: begin
            if (!mode_req) begin
               state_nxt_s = ST_DSHOT;
            end else if (!dshot_busy) begin
               state_nxt_s = ST_SETTLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_SETTLE: begin
            if (!mode_req) begin
               state_nxt_s = ST_DSHOT;
            end else if (settle_cnt_r == (SETTLE_CYCLES - 32'd1)) begin
               state_nxt_s = ST_PASS;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         ST_PASS: begin
            if (!mode_req || timeout_s) begin
               state_nxt_s = ST_RELEASE;
            end else begin
               state_nxt_s = ST_PASS;
            end
         end
         ST_RELEASE: begin
            // Guard count only advances while the bridge has released the pin.
            if (!serial_tx_oe && (guard_cnt_r == GUARD_CYCLES)) begin
               state_nxt_s = ST_DSHOT;
            end else begin
               state_nxt_s = ST_RELEASE;
            end
         end
         default: begin
            state_nxt_s = ST_DSHOT;
         end
      endcase
   end

   // Pin and handshake values for the state being entered.
   always_comb begin
      pad_oe_nxt_s         = 1'b1;
      pad_out_nxt_s        = 1'b1;
      passthrough_en_nxt_s = 1'b0;
      dshot_inhibit_nxt_s  = 1'b1;
      case (state_nxt_s)
         ST_DSHOT: begin
            pad_oe_nxt_s         = 1'b1;
            pad_out_nxt_s        = dshot_out;
            passthrough_en_nxt_s = 1'b0;
            dshot_inhibit_nxt_s  = 1'b0;
         end
         ST_DRAIN: begin
            pad_oe_nxt_s         = 1'b1;
            pad_out_nxt_s        = dshot_out;
            passthrough_en_nxt_s = 1'b0;
            dshot_inhibit_nxt_s  = 1'b1;
         end
         ST_SETTLE: begin
            pad_oe_nxt_s         = 1'b1;
            pad_out_nxt_s        = 1'b1;
            passthrough_en_nxt_s = 1'b0;
            dshot_inhibit_nxt_s  = 1'b1;
         end
         ST_PASS: begin
            pad_oe_nxt_s         = serial_tx_oe;
            pad_out_nxt_s        = serial_tx_out;
            passthrough_en_nxt_s = 1'b1;
            dshot_inhibit_nxt_s  = 1'b1;
         end
         ST_RELEASE: begin
            pad_oe_nxt_s         = serial_tx_oe;
            pad_out_nxt_s        = serial_tx_out;
            passthrough_en_nxt_s = 1'b0;
            dshot_inhibit_nxt_s  = 1'b1;
         end
         default: begin
            pad_oe_nxt_s         = 1'b0;
            pad_out_nxt_s        = 1'b0;
            passthrough_en_nxt_s = 1'b0;
            dshot_inhibit_nxt_s  = 1'b1;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_DSHOT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Settle counter: counts only while staying in SETTLE, zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt_r <= 32'd0;
      end else if ((state_r == ST_SETTLE) && (state_nxt_s == ST_SETTLE)) begin
         settle_cnt_r <= settle_cnt_r + 32'd1;
      end else begin
         settle_cnt_r <= 32'd0;
      end
   end

   // Release guard: restarts whenever the bridge drives the pin again.
   always_ff @(posedge clk) begin
      if (rst) begin
         guard_cnt_r <= 32'd0;
      end else if ((state_r == ST_RELEASE) && (state_nxt_s == ST_RELEASE) && !serial_tx_oe) begin
         guard_cnt_r <= guard_cnt_r + 32'd1;
      end else begin
         guard_cnt_r <= 32'd0;
      end
   end

   // Pin output and handshake registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pad_oe_r         <= 1'b0;
         pad_out_r        <= 1'b0;
         passthrough_en_r <= 1'b0;
         dshot_inhibit_r  <= 1'b0;
      end else begin
         pad_oe_r         <= pad_oe_nxt_s;
         pad_out_r        <= pad_out_nxt_s;
         passthrough_en_r <= passthrough_en_nxt_s;
         dshot_inhibit_r  <= dshot_inhibit_nxt_s;
      end
   end

   // Two-stage synchronizer; idles high like the line itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         pad_sync1_r <= 1'b1;
         pad_sync2_r <= 1'b1;
      end else begin
         pad_sync1_r <= pad_in;
         pad_sync2_r <= pad_sync1_r;
      end
   end

   // Echo guard: reloaded every cycle the pin is driven, so it restarts on each release.
   always_ff @(posedge clk) begin
      if (rst) begin
         echo_cnt_r <= 32'd0;
      end else if (pad_oe_r) begin
         echo_cnt_r <= GUARD_CYCLES;
      end else if (echo_cnt_r != 32'd0) begin
         echo_cnt_r <= echo_cnt_r - 32'd1;
      end
   end

   // Receive data to the bridge, held high while blanked.
   always_ff @(posedge clk) begin
      if (rst) begin
         serial_rx_r <= 1'b1;
      end else if (pad_oe_r || (echo_cnt_r != 32'd0)) begin
         serial_rx_r <= 1'b1;
      end else begin
         serial_rx_r <= pad_sync2_r;
      end
   end

   assign pad_oe         = pad_oe_r;
   assign pad_out        = pad_out_r;
   assign passthrough_en = passthrough_en_r;
   assign dshot_inhibit  = dshot_inhibit_r;
   assign serial_rx_in   = serial_rx_r;
   assign mode_state     = state_r;

endmodule

// File: tb/tb_esc_pin_mux.sv
// -----------------------------------------------------------------------------
// tb_esc_pin_mux
//
// Directed bench for esc_pin_mux. Each step drives inputs, pushes the output
// vector expected after the next clock edge onto a scoreboard queue, then pops
// and compares it one time unit after that edge. The pin is modelled as the
// DUT driver in parallel with an external level source (ext_in).
// Vector layout: {mode_state[2:0], pad_oe, pad_out, serial_rx_in,
//                 passthrough_en, dshot_inhibit, timeout_evt}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_esc_pin_mux;

   localparam int unsigned SETTLE = 32'd300;
   localparam int unsigned GUARD  = 32'd720;
   localparam int unsigned IDLE   = 32'd1000;

   localparam logic [8:0] M_ALL = 9'h1FF;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_req;
   logic       dshot_out;
   logic       dshot_busy;
   logic       dshot_inhibit;
   logic       serial_tx_out;
   logic       serial_tx_oe;
   logic       serial_rx_in;
   logic       serial_activity;
   logic       passthrough_en;
   logic       pad_in;
   logic       pad_out;
   logic       pad_oe;
   logic [2:0] mode_state;
   logic       timeout_evt;
   logic       ext_in;

   string      tag_q[$];
   logic [17:0] exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   // Pin: DUT driver wins when enabled, otherwise the external level.
   assign pad_in = pad_oe ? pad_out : ext_in;

   esc_pin_mux #(
      .CLK_FREQ_HZ        (32'd72_000_000),
      .SETTLE_CYCLES      (SETTLE),
      .GUARD_CYCLES       (GUARD),
      .IDLE_TIMEOUT_CYCLES(IDLE)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mode_req       (mode_req),
      .dshot_out      (dshot_out),
      .dshot_busy     (dshot_busy),
      .dshot_inhibit  (dshot_inhibit),
      .serial_tx_out  (serial_tx_out),
      .serial_tx_oe   (serial_tx_oe),
      .serial_rx_in   (serial_rx_in),
      .serial_activity(serial_activity),
      .passthrough_en (passthrough_en),
      .pad_in         (pad_in),
      .pad_out        (pad_out),
      .pad_oe         (pad_oe),
      .mode_state     (mode_state),
      .timeout_evt    (timeout_evt)
   );

   task automatic push_exp(input string tag, input logic [2:0] ms, input logic oe,
                           input logic out, input logic rx, input logic pten,
                           input logic inh, input logic evt, input logic [8:0] mask);
      tag_q.push_back(tag);
      exp_q.push_back({mask, ms, oe, out, rx, pten, inh, evt});
   endtask

   task automatic pop_check();
      string       tag;
      logic [17:0] e;
      logic [8:0]  obs;
      @(posedge clk);
      #1;
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      obs = {mode_state, pad_oe, pad_out, serial_rx_in, passthrough_en, dshot_inhibit, timeout_evt};
      vectors++;
      assert ((obs & e[17:9]) === (e[8:0] & e[17:9])) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b (mask %b)", tag, obs, e[8:0], e[17:9]);
      end
   endtask

   task automatic cyc(input string tag, input logic [2:0] ms, input logic oe,
                      input logic out, input logic rx, input logic pten,
                      input logic inh, input logic evt);
      push_exp(tag, ms, oe, out, rx, pten, inh, evt, M_ALL);
      pop_check();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  dpat;
      logic [15:0] tpat;
      dpat = 8'b1011_0010;
      tpat = 16'b1100_1010_0111_0001;

      rst = 1'b1; mode_req = 1'b0; dshot_out = 1'b0; dshot_busy = 1'b0;
      serial_tx_out = 1'b1; serial_tx_oe = 1'b0; serial_activity = 1'b0; ext_in = 1'b1;
      #2;

      // Reset values.
      cyc("reset", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("reset_hold", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // DSHOT: pad follows dshot_out one cycle later.
      for (int i = 0; i < 8; i++) begin
         dshot_out = dpat[i];
         cyc("dshot_follow", 3'd0, 1'b1, dpat[i], 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // DRAIN for 50 cycles while the frame finishes.
      mode_req = 1'b1; dshot_busy = 1'b1;
      for (int i = 0; i < 50; i++) begin
         dshot_out = i[0];
         cyc("drain", 3'd1, 1'b1, i[0], 1'b1, 1'b0, 1'b1, 1'b0);
      end

      // SETTLE lasts exactly SETTLE cycles with the pin forced high.
      dshot_busy = 1'b0;
      for (int i = 0; i < int'(SETTLE); i++) begin
         dshot_out = i[1];
         cyc("settle", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      serial_activity = 1'b1;
      cyc("pass_entry", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

      // Let the entry echo window expire.
      for (int i = 0; i < int'(GUARD) + 5; i++) begin
         cyc("pass_idle", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      end

      // Pin to serial_rx_in latency of 3 cycles, both polarities.
      ext_in = 1'b0;
      cyc("pin_lat_fall1", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc("pin_lat_fall2", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc("pin_lat_fall3", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      ext_in = 1'b1;
      cyc("pin_lat_rise1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("pin_lat_rise2", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("pin_lat_rise3", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

      // Transmit 100 cycles with loopback: receiver stays blanked.
      serial_tx_oe = 1'b1;
      for (int i = 0; i < 100; i++) begin
         serial_tx_out = tpat[i % 16];
         cyc("echo_tx", 3'd3, 1'b1, tpat[i % 16], 1'b1, 1'b1, 1'b1, 1'b0);
      end
      serial_tx_oe = 1'b0; serial_tx_out = 1'b1; ext_in = 1'b0;
      for (int i = 0; i <= int'(GUARD); i++) begin
         cyc("echo_guard", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      end
      cyc("echo_end", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

      ext_in = 1'b1;
      push_exp("pass_resync", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 9'h1F7);
      pop_check();
      push_exp("pass_resync", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 9'h1F7);
      pop_check();
      cyc("pass_resync3", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

      // Drop mode_req while transmitting: RELEASE until tx_oe falls plus guard.
      serial_tx_oe = 1'b1; mode_req = 1'b0; dshot_out = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc("release_tx", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      serial_tx_oe = 1'b0;
      for (int i = 0; i < int'(GUARD); i++) begin
         cyc("release_guard", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      cyc("release_exit", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // DRAIN lasts one cycle even when idle; SETTLE aborts straight to DSHOT.
      mode_req = 1'b1; dshot_out = 1'b0;
      cyc("drain_min", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc("settle_short", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      mode_req = 1'b0;
      cyc("settle_abort", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // DRAIN abort.
      mode_req = 1'b1; dshot_busy = 1'b1;
      cyc("drain_abort_in", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      mode_req = 1'b0;
      cyc("drain_abort", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      dshot_busy = 1'b0;

      // Idle PASS: auto-revert when built in, otherwise PASS is held.
      serial_activity = 1'b0; mode_req = 1'b1;
      cyc("idle_drain", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < int'(SETTLE); i++) begin
         cyc("idle_settle", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      cyc("idle_pass_entry", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef ESC_MUX_AUTO_REVERT_EN
      for (int m = 1; m < int'(IDLE); m++) begin
         cyc("idle_wait", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      end
      cyc("timeout_pulse", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < int'(GUARD); i++) begin
         cyc("timeout_release", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      cyc("timeout_exit", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc("lock_hold", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      mode_req = 1'b0;
      cyc("lock_clear", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      mode_req = 1'b1;
      cyc("relock_entry", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      mode_req = 1'b0;
      cyc("relock_abort", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`else
      for (int m = 1; m < int'(IDLE) + 100; m++) begin
         cyc("no_timeout", 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      end
      mode_req = 1'b0;
      cyc("manual_release", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < int'(GUARD); i++) begin
         cyc("manual_guard", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      cyc("manual_exit", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

      // Reset during SETTLE returns to reset values on the next edge.
      mode_req = 1'b1;
      cyc("rst_drain", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("rst_settle_a", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("rst_settle_b", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      cyc("rst_in_settle", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; mode_req = 1'b0; dshot_out = 1'b1;
      cyc("post_rst", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
